// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared types and helpers for the SRAM arbiter/controller.
//   state_t : access sequencer phases (IDLE, SETUP, PULSE, HOLD)
//   port_t  : requester identity (PORT_A = CPU, PORT_B = loader/DMA)
//   cnt_width() : phase down-counter width from the three timing parameters
package sram_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    // The counter only ever holds N-1 for the longest phase.
    function automatic int cnt_width(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_if.sv
// Requester-side bundle of the SRAM arbiter: two request ports (A, B) with
// their one-cycle acks, plus the shared read-data return.
//   master : driven by the requesters (req/we/addr/wdata), sees ack/rData
//   slave  : the controller side
interface sram_arbiter_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic                  aReq;
    logic                  aWe;
    logic [ADDR_WIDTH-1:0] aAddr;
    logic [DATA_WIDTH-1:0] aWData;
    logic                  aAck;
    logic                  bReq;
    logic                  bWe;
    logic [ADDR_WIDTH-1:0] bAddr;
    logic [DATA_WIDTH-1:0] bWData;
    logic                  bAck;
    logic [DATA_WIDTH-1:0] rData;

    modport master (output aReq, aWe, aAddr, aWData, bReq, bWe, bAddr, bWData,
                    input  aAck, bAck, rData);
    modport slave  (input  aReq, aWe, aAddr, aWData, bReq, bWe, bAddr, bWData,
                    output aAck, bAck, rData);
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant, purely combinational.
//   aReq_i/bReq_i : pending requests
//   lastGrant_i   : port that won the previous tie
//   anyReq_o      : at least one request pending
//   grant_o       : selected port
//   updLast_o     : a tie was resolved, so lastGrant must take grant_o
module sram_rr_arbiter
    import sram_arbiter_ctrl_pkg::*;
(
    input  logic  aReq_i,
    input  logic  bReq_i,
    input  port_t lastGrant_i,
    output logic  anyReq_o,
    output port_t grant_o,
    output logic  updLast_o
);
    always_comb begin
        anyReq_o  = aReq_i | bReq_i;
        updLast_o = aReq_i & bReq_i;
        grant_o   = PORT_A;
        if (aReq_i && bReq_i)
            grant_o = (lastGrant_i == PORT_A) ? PORT_B : PORT_A;
        else if (bReq_i)
            grant_o = PORT_B;
    end
endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Asynchronous-SRAM access sequencer shared by two synchronous requesters.
// Each access runs IDLE -> SETUP -> PULSE -> HOLD -> IDLE with cycle counts
// set by parameters; all SRAM strobes, the bus drive enable and the acks are
// registered.
//   clk, notReset : clock, synchronous active-low reset
//   bus           : request ports A/B, acks, shared read data (slave side)
//   ramAddr       : SRAM address, held between accesses
//   ramData       : SRAM data bus, driven only during write accesses
//   ramNotCS/OE/WE: active-low SRAM strobes
module sram_arbiter_ctrl
    import sram_arbiter_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  notReset,
    sram_arbiter_ctrl_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    inout  wire  [DATA_WIDTH-1:0] ramData,
    output logic                  ramNotCS,
    output logic                  ramNotOE,
    output logic                  ramNotWE
);
    localparam int CW = cnt_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    port_t                 grant_q, grant_d, last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  aAck_q, aAck_d, bAck_q, bAck_d;
    logic                  ncs_q, ncs_d, noe_q, noe_d, nwe_q, nwe_d;
    logic                  drv_q, drv_d;
    logic                  busy, hold_end;

    logic  arb_any, arb_upd;
    port_t arb_grant;

    sram_rr_arbiter u_arb (
        .aReq_i     (bus.aReq),
        .bReq_i     (bus.bReq),
        .lastGrant_i(last_q),
        .anyReq_o   (arb_any),
        .grant_o    (arb_grant),
        .updLast_o  (arb_upd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (arb_any) begin
                state_d = SETUP;
                cnt_d   = SETUP_LD;
                grant_d = arb_grant;
                if (arb_upd) last_d = arb_grant;
                if (arb_grant == PORT_A) begin
                    we_d = bus.aWe;  addr_d = bus.aAddr;  wdata_d = bus.aWData;
                end else begin
                    we_d = bus.bWe;  addr_d = bus.bAddr;  wdata_d = bus.bWData;
                end
            end
            SETUP: if (cnt_q == '0) begin
                state_d = PULSE;
                cnt_d   = PULSE_LD;
            end else cnt_d = cnt_q - 1'b1;
            PULSE: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = HOLD_LD;
                // Capture at the edge closing the last OE-low cycle.
                if (!we_q) rdata_d = ramData;
            end else cnt_d = cnt_q - 1'b1;
            HOLD: if (cnt_q == '0) state_d = IDLE;
                  else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies, so
        // they change exactly with the state and never glitch from req.
        busy     = (state_d != IDLE);
        hold_end = (state_d == HOLD) && (cnt_d == '0);
        ncs_d    = !busy;
        noe_d    = !((state_d == PULSE) && !we_d);
        nwe_d    = !((state_d == PULSE) && we_d);
        drv_d    = busy && we_d;
        aAck_d   = hold_end && (grant_d == PORT_A);
        bAck_d   = hold_end && (grant_d == PORT_B);
    end

    always_ff @(posedge clk) begin
        if (!notReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= PORT_A;
            last_q  <= PORT_B;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            aAck_q  <= 1'b0;
            bAck_q  <= 1'b0;
            ncs_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            aAck_q  <= aAck_d;
            bAck_q  <= bAck_d;
            ncs_q   <= ncs_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            drv_q   <= drv_d;
        end
    end

    assign ramAddr   = addr_q;
    assign ramData   = drv_q ? wdata_q : 'z;
    assign ramNotCS  = ncs_q;
    assign ramNotOE  = noe_q;
    assign ramNotWE  = nwe_q;
    assign bus.aAck  = aAck_q;
    assign bus.bAck  = bAck_q;
    assign bus.rData = rdata_q;
endmodule
